// File: rtl/en_link_pkg.sv
// Shared framing definitions for the single-wire enable link.
// The transmitter and receiver both import this so their framing always matches.
package en_link_pkg;

  // Line levels for the start bit, the stop bit and the idle line
  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

  // Default framing: clocks per line bit and payload bits per frame
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int DEF_DATA_BITS    = 2;

  // Receiver frame-tracking states
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/en_pair_rx_if.sv
// Valid/ack output bus of the enable-link receiver.
// The master drives the payload and valid; the slave returns ack.
interface en_pair_rx_if
  import en_link_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ack;

  modport master (
    output data_out,
    output data_valid,
    input  data_ack
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ack
  );

endinterface

// File: rtl/en_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Used on the receive line here and reusable on the transmitter's ack path.
module en_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/en_pair_rx.sv
// Receiver for the single-wire enable link.
// Recovers the framed per-channel enable bits from line_in and presents them
// as a parallel word with a valid/ack handshake.
module en_pair_rx
  import en_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         line_in,
  en_pair_rx_if.master rx_bus,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS) + 1;

  // Half-bit reload centres every later sample in the middle of its bit
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

  logic                 line_s;
  logic                 line_prev;
  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_good;
  logic                 frame_bad;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;

  en_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (line_in),
    .q   (line_s)
  );

  assign rx_bus.data_out   = data_q;
  assign rx_bus.data_valid = valid_q;

  // Frame FSM plus output registers; a finished frame is published one cycle after its stop sample
  always_ff @(posedge clk) begin
    if (rst) begin
      line_prev  <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      line_prev <= line_s;
      if (!ena) begin
        state      <= IDLE;
        cnt        <= '0;
        bit_idx    <= '0;
        frame_good <= 1'b0;
        frame_bad  <= 1'b0;
        frame_err  <= 1'b0;
        busy       <= 1'b0;
      end else begin
        frame_good <= 1'b0;
        frame_bad  <= 1'b0;
        frame_err  <= frame_bad;

        if (frame_good) begin
          data_q  <= shreg;
          valid_q <= 1'b1;
          if (valid_q && !rx_bus.data_ack) begin
            overrun <= 1'b1;
          end
        end else if (valid_q && rx_bus.data_ack) begin
          valid_q <= 1'b0;
        end

        case (state)
          IDLE: begin
            if (line_prev == IDLE_LVL && line_s == START_LVL) begin
              state <= START;
              cnt   <= HALF_LOAD;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (line_s == START_LVL) begin
              state   <= DATA;
              cnt     <= FULL_LOAD;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          DATA: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              for (int i = 0; i < DATA_BITS; i++) begin
                if (bit_idx == IW'(i)) begin
                  shreg[i] <= line_s;
                end
              end
              cnt <= FULL_LOAD;
              if (bit_idx == LAST_BIT) begin
                state   <= STOP;
                bit_idx <= '0;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
          STOP: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              if (line_s == STOP_LVL) begin
                frame_good <= 1'b1;
              end else begin
                frame_bad <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_en_pair_rx.sv
// Scoreboard bench for en_pair_rx: stimulus pushes expected frame results,
// a monitor pops and compares whenever the receiver presents a frame or an error.
module tb_en_pair_rx;
  import en_link_pkg::*;

  localparam int CPB = 4;
  localparam int DB  = 2;
  localparam int LATENCY = 2 + CPB / 2 + (DB + 1) * CPB + 1;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic line_in;
  logic frame_err;
  logic overrun;
  logic busy;

  en_pair_rx_if #(.DATA_BITS(DB)) bus ();

  en_pair_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .line_in   (line_in),
    .rx_bus    (bus),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_err;
    logic [DB-1:0] data;
    logic        ovr;
    int          due;
  } exp_t;

  exp_t expq[$];

  logic          mon_prev_valid = 1'b0;
  logic [DB-1:0] mon_prev_data  = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Sends one frame starting at the next falling edge and queues its expected result
  task automatic applyStimulus(input logic [DB-1:0] data, input logic stop_bit,
                               input logic [DB-1:0] exp_data, input logic exp_ovr,
                               input bit keep_line);
    exp_t e;
    @(negedge clk);
    e.is_err = (stop_bit != STOP_LVL);
    e.data   = exp_data;
    e.ovr    = exp_ovr;
    e.due    = cyc + 1 + LATENCY;
    expq.push_back(e);
    line_in = START_LVL;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      line_in = data[i];
      repeat (CPB) @(negedge clk);
    end
    line_in = stop_bit;
    repeat (CPB) @(negedge clk);
    if (!keep_line) line_in = IDLE_LVL;
  endtask

  task automatic ackOnce();
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
  endtask

  // Monitor: a frame is presented when valid rises or the payload changes while valid
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (frame_err || (bus.data_valid && (!mon_prev_valid || bus.data_out != mon_prev_data))) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_event", {30'd0, frame_err, bus.data_valid}, 32'd0);
        end else begin
          e = expq.pop_front();
          checkOutput("frame_err", frame_err, e.is_err);
          checkOutput("data_out", bus.data_out, e.data);
          checkOutput("overrun", overrun, e.ovr);
          checkOutput("arrival_cycle", cyc, e.due);
        end
      end
      mon_prev_valid = bus.data_valid;
      mon_prev_data  = bus.data_out;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] pattern;
    logic       busy_seen;

    rst = 1'b1;
    ena = 1'b1;
    line_in = IDLE_LVL;
    bus.data_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_data_out", bus.data_out, 0);
    checkOutput("rst_data_valid", bus.data_valid, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_busy", busy, 0);
    repeat (4) @(negedge clk);

    $display("[TB] basic frame 01");
    applyStimulus(2'b01, STOP_LVL, 2'b01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("t1_valid_held", bus.data_valid, 1);
    ackOnce();
    checkOutput("t1_valid_after_ack", bus.data_valid, 0);
    repeat (4) @(negedge clk);

    $display("[TB] ack coinciding with frame completion");
    applyStimulus(2'b10, STOP_LVL, 2'b10, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(2'b11, STOP_LVL, 2'b11, 1'b0, 1'b0);
    @(negedge clk);
    bus.data_ack = 1'b1;
    @(negedge clk);
    bus.data_ack = 1'b0;
    checkOutput("coinc_valid", bus.data_valid, 1);
    checkOutput("coinc_overrun", overrun, 0);
    checkOutput("coinc_data", bus.data_out, 2'b11);
    ackOnce();
    checkOutput("coinc_valid_cleared", bus.data_valid, 0);
    repeat (4) @(negedge clk);

    $display("[TB] one-cycle glitch");
    pattern = '0;
    line_in = START_LVL;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) line_in = IDLE_LVL;
      pattern = {pattern[4:0], busy};
    end
    checkOutput("glitch_busy_pattern", pattern, 6'b001100);
    checkOutput("glitch_valid", bus.data_valid, 0);
    repeat (4) @(negedge clk);

    $display("[TB] bad stop bit with line left high");
    applyStimulus(2'b01, ~STOP_LVL, 2'b11, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("ferr_one_cycle", frame_err, 0);
    busy_seen = 1'b0;
    repeat (16) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    checkOutput("stuck_high_no_rearm", busy_seen, 0);
    checkOutput("ferr_data_kept", bus.data_out, 2'b11);
    checkOutput("ferr_no_valid", bus.data_valid, 0);
    line_in = IDLE_LVL;
    repeat (4) @(negedge clk);

    $display("[TB] overrun");
    applyStimulus(2'b10, STOP_LVL, 2'b10, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(2'b11, STOP_LVL, 2'b11, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("ovr_flag", overrun, 1);
    checkOutput("ovr_valid", bus.data_valid, 1);
    checkOutput("ovr_data", bus.data_out, 2'b11);
    repeat (4) @(negedge clk);

    $display("[TB] ena dropped mid-frame");
    line_in = START_LVL;
    repeat (6) @(negedge clk);
    checkOutput("ena_busy_before", busy, 1);
    ena = 1'b0;
    line_in = IDLE_LVL;
    @(negedge clk);
    checkOutput("ena_busy_after", busy, 0);
    checkOutput("ena_data_hold", bus.data_out, 2'b11);
    checkOutput("ena_valid_hold", bus.data_valid, 1);
    checkOutput("ena_overrun_hold", overrun, 1);
    checkOutput("ena_frame_err", frame_err, 0);
    repeat (4) @(negedge clk);
    ena = 1'b1;
    repeat (8) @(negedge clk);

    $display("[TB] reset mid-frame");
    line_in = START_LVL;
    repeat (6) @(negedge clk);
    checkOutput("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    line_in = IDLE_LVL;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_data", bus.data_out, 0);
    checkOutput("rst_mid_valid", bus.data_valid, 0);
    checkOutput("rst_mid_overrun", overrun, 0);
    checkOutput("rst_mid_frame_err", frame_err, 0);
    repeat (4) @(negedge clk);
    applyStimulus(2'b01, STOP_LVL, 2'b01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("post_rst_valid", bus.data_valid, 1);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
